// File: rtl/dcnn_s1_chain_ctrl.sv
// Entrance sequencer for the stride-1 chain PE array.
// Streams tagged kernel words, then pixel passes separated by weight-advance gaps.
module dcnn_s1_chain_ctrl #(
  parameter int DW       = 16,
  parameter int K_BITS   = 4,
  parameter int PARA     = 144,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                rst_n,
  input  logic                cmd_load,
  input  logic                cmd_run,
  input  logic [CNT_BITS-1:0] cfg_n_weights,
  input  logic [CNT_BITS-1:0] cfg_beats,
  input  logic [CNT_BITS-1:0] cfg_passes,
  input  logic [CNT_BITS-1:0] cfg_drain,
  input  logic [K_BITS-1:0]   cfg_k_size,
  input  logic                cfg_attr,
  input  logic [DW-1:0]       w_data,
  input  logic [9:0]          w_idx,
  input  logic                w_val,
  output logic                w_rdy,
  input  logic [DW-1:0]       px_data0,
  input  logic [DW-1:0]       px_data1,
  input  logic                px_val,
  output logic                px_rdy,
  output logic                mode_kernel_load,
  output logic [DW-1:0]       x_entrance0,
  output logic [DW-1:0]       x_entrance1,
  output logic [1:0]          y_entrance_vld,
  output logic                entrance_attribute,
  output logic [K_BITS-1:0]   k_size,
  output logic                busy,
  output logic                done,
  output logic                err_underrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_KLOAD, S_KTAIL, S_CONV, S_GAP, S_DRAIN
  } state_t;

  localparam logic [DW-1:0]       IDLE_TAG = {{(DW-10){1'b0}}, 10'h3FF};
  localparam logic [CNT_BITS-1:0] TAIL_LEN = CNT_BITS'(PARA + 1);
  localparam logic [CNT_BITS-1:0] ONE      = CNT_BITS'(1);

  state_t              state_q;
  logic [CNT_BITS-1:0] cnt_q;
  logic [CNT_BITS-1:0] pass_q;
  logic [CNT_BITS-1:0] beats_q;
  logic [CNT_BITS-1:0] drain_q;
  logic [K_BITS-1:0]   k_q;
  logic                attr_q;
  logic                fin_q;
  logic                w_hs;
  logic                beat;
  logic                run_st;

  assign w_rdy  = (state_q == S_KLOAD) && (cnt_q != '0);
  assign px_rdy = (state_q == S_CONV);
  assign busy   = (state_q != S_IDLE);
  assign w_hs   = w_rdy && w_val;
  assign beat   = (cnt_q != '0) || px_val;
  assign run_st = (state_q == S_CONV) || (state_q == S_GAP) ||
                  (state_q == S_DRAIN);

  // fin_q marks the terminal transition; done follows one cycle later
  // so it lines up with the last registered entrance cycle.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q            <= S_IDLE;
      cnt_q              <= '0;
      pass_q             <= '0;
      beats_q            <= '0;
      drain_q            <= '0;
      k_q                <= '0;
      attr_q             <= 1'b0;
      fin_q              <= 1'b0;
      mode_kernel_load   <= 1'b0;
      x_entrance0        <= '0;
      x_entrance1        <= '0;
      y_entrance_vld     <= 2'b00;
      entrance_attribute <= 1'b0;
      k_size             <= '0;
      done               <= 1'b0;
      err_underrun       <= 1'b0;
    end else if (!rst_n) begin
      state_q            <= S_IDLE;
      cnt_q              <= '0;
      pass_q             <= '0;
      beats_q            <= '0;
      drain_q            <= '0;
      k_q                <= '0;
      attr_q             <= 1'b0;
      fin_q              <= 1'b0;
      mode_kernel_load   <= 1'b0;
      x_entrance0        <= '0;
      x_entrance1        <= '0;
      y_entrance_vld     <= 2'b00;
      entrance_attribute <= 1'b0;
      k_size             <= '0;
      done               <= 1'b0;
      err_underrun       <= 1'b0;
    end else begin
      done               <= fin_q;
      fin_q              <= 1'b0;
      x_entrance0        <= '0;
      x_entrance1        <= '0;
      y_entrance_vld     <= 2'b00;
      mode_kernel_load   <= (state_q == S_KLOAD) ||
                            (state_q == S_KTAIL);
      entrance_attribute <= run_st ? attr_q : 1'b0;
      k_size             <= run_st ? k_q : '0;
      unique case (state_q)
        S_IDLE: begin
          if (cmd_load) begin
            if (cfg_n_weights == '0) begin
              state_q <= S_KTAIL;
              cnt_q   <= TAIL_LEN;
            end else begin
              state_q <= S_KLOAD;
              cnt_q   <= cfg_n_weights;
            end
          end else if (cmd_run) begin
            beats_q      <= cfg_beats;
            drain_q      <= cfg_drain;
            k_q          <= cfg_k_size;
            attr_q       <= cfg_attr;
            pass_q       <= cfg_passes;
            err_underrun <= 1'b0;
            cnt_q        <= '0;
            if (cfg_beats == '0 || cfg_passes == '0) begin
              if (cfg_drain == '0) begin
                fin_q <= 1'b1;
              end else begin
                state_q <= S_DRAIN;
                cnt_q   <= cfg_drain;
              end
            end else begin
              state_q <= S_CONV;
            end
          end
        end
        S_KLOAD: begin
          x_entrance1 <= IDLE_TAG;
          if (w_hs) begin
            x_entrance0 <= w_data;
            x_entrance1 <= {{(DW-10){1'b0}}, w_idx};
            cnt_q       <= cnt_q - ONE;
            if (cnt_q == ONE) begin
              state_q <= S_KTAIL;
              cnt_q   <= TAIL_LEN;
            end
          end
        end
        S_KTAIL: begin
          x_entrance1 <= IDLE_TAG;
          if (cnt_q <= ONE) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            fin_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - ONE;
          end
        end
        S_CONV: begin
          if (cnt_q == '0) begin
            if (px_val) begin
              y_entrance_vld <= 2'b11;
              x_entrance0    <= px_data0;
              x_entrance1    <= px_data1;
            end
          end else begin
            y_entrance_vld <= 2'b01;
            if (px_val) begin
              x_entrance0 <= px_data0;
              x_entrance1 <= px_data1;
            end else begin
              err_underrun <= 1'b1;
            end
          end
          if (beat) begin
            cnt_q <= cnt_q + ONE;
            if (cnt_q + ONE == beats_q) begin
              state_q <= S_GAP;
              cnt_q   <= '0;
            end
          end
        end
        S_GAP: begin
          pass_q <= pass_q - ONE;
          if (pass_q > ONE) begin
            state_q <= S_CONV;
          end else if (drain_q == '0) begin
            state_q <= S_IDLE;
            fin_q   <= 1'b1;
          end else begin
            state_q <= S_DRAIN;
            cnt_q   <= drain_q;
          end
        end
        S_DRAIN: begin
          if (cnt_q <= ONE) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            fin_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - ONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcnn_s1_chain_ctrl.sv
// Directed bench for dcnn_s1_chain_ctrl: kernel load, passes,
// underrun, command priority and mid-sequence reset.
module tb_dcnn_s1_chain_ctrl;

  logic        clk = 1'b0;
  logic        arst_n, rst_n;
  logic        cmd_load, cmd_run;
  logic [15:0] cfg_n_weights, cfg_beats, cfg_passes, cfg_drain;
  logic [3:0]  cfg_k_size;
  logic        cfg_attr;
  logic [15:0] w_data;
  logic [9:0]  w_idx;
  logic        w_val, w_rdy;
  logic [15:0] px_data0, px_data1;
  logic        px_val, px_rdy;
  logic        mode_kernel_load;
  logic [15:0] x_entrance0, x_entrance1;
  logic [1:0]  y_entrance_vld;
  logic        entrance_attribute;
  logic [3:0]  k_size;
  logic        busy, done, err_underrun;

  int n_run  = 0;
  int n_fail = 0;

  logic [15:0] wd [3];
  logic [9:0]  wt [3];

  logic [15:0] rx0  [0:199];
  logic [15:0] rx1  [0:199];
  logic [1:0]  rvld [0:199];
  logic        rmode[0:199];
  logic        rdone[0:199];
  logic        rrdy [0:199];
  logic        rbusy[0:199];
  logic        rerr [0:199];
  logic        rattr[0:199];
  logic [3:0]  rk   [0:199];

  dcnn_s1_chain_ctrl dut (
    .clk(clk), .arst_n(arst_n), .rst_n(rst_n),
    .cmd_load(cmd_load), .cmd_run(cmd_run),
    .cfg_n_weights(cfg_n_weights), .cfg_beats(cfg_beats),
    .cfg_passes(cfg_passes), .cfg_drain(cfg_drain),
    .cfg_k_size(cfg_k_size), .cfg_attr(cfg_attr),
    .w_data(w_data), .w_idx(w_idx), .w_val(w_val), .w_rdy(w_rdy),
    .px_data0(px_data0), .px_data1(px_data1),
    .px_val(px_val), .px_rdy(px_rdy),
    .mode_kernel_load(mode_kernel_load),
    .x_entrance0(x_entrance0), .x_entrance1(x_entrance1),
    .y_entrance_vld(y_entrance_vld),
    .entrance_attribute(entrance_attribute),
    .k_size(k_size), .busy(busy), .done(done),
    .err_underrun(err_underrun)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue a command at the current cycle T, then record L cycles.
  // rec[c] holds the outputs seen in cycle T+c.
  task automatic seq(bit ld, bit rn, int len, int gap_at,
                     int poke_at, int under_at);
    int  wi;
    bit  hs;
    wi       = 0;
    cmd_load = ld;
    cmd_run  = rn;
    @(posedge clk); #1;
    cmd_load = 1'b0;
    cmd_run  = 1'b0;
    for (int c = 1; c <= len; c++) begin
      rx0[c]   = x_entrance0;
      rx1[c]   = x_entrance1;
      rvld[c]  = y_entrance_vld;
      rmode[c] = mode_kernel_load;
      rdone[c] = done;
      rrdy[c]  = w_rdy;
      rbusy[c] = busy;
      rerr[c]  = err_underrun;
      rattr[c] = entrance_attribute;
      rk[c]    = k_size;
      w_val    = (c != gap_at);
      w_data   = wd[wi];
      w_idx    = wt[wi];
      px_val   = (c != under_at);
      px_data0 = 16'h0100 + 16'(c);
      px_data1 = 16'h0200 + 16'(c);
      cmd_run  = (c == poke_at);
      hs       = w_val && w_rdy;
      @(posedge clk); #1;
      if (hs && wi < 2) wi++;
    end
    cmd_run = 1'b0;
    w_val   = 1'b0;
    px_val  = 1'b0;
  endtask

  initial begin
    int n;
    wd[0] = 16'hA001; wd[1] = 16'hB002; wd[2] = 16'hC003;
    wt[0] = 10'd0;    wt[1] = 10'd5;    wt[2] = 10'd144;
    arst_n = 1'b0; rst_n = 1'b1;
    cmd_load = 1'b0; cmd_run = 1'b0;
    cfg_n_weights = 16'd3; cfg_beats = 16'd9;
    cfg_passes = 16'd2; cfg_drain = 16'd4;
    cfg_k_size = 4'd3; cfg_attr = 1'b1;
    w_data = '0; w_idx = '0; w_val = 1'b0;
    px_data0 = '0; px_data1 = '0; px_val = 1'b0;
    #2;
    check("rst_mode", 32'(mode_kernel_load), 0);
    check("rst_x1", 32'(x_entrance1), 0);
    check("rst_vld", 32'(y_entrance_vld), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err_underrun), 0);
    check("rst_k", 32'(k_size), 0);
    #10 arst_n = 1'b1;
    @(posedge clk); #1;

    // Load, N=3, w_val held high
    seq(1, 0, 155, 0, 0, 0);
    check("ld_busy1", 32'(rbusy[1]), 1);
    check("ld_mode1", 32'(rmode[1]), 0);
    check("ld_tag0", 32'(rx1[2]), 0);
    check("ld_tag1", 32'(rx1[3]), 5);
    check("ld_tag2", 32'(rx1[4]), 144);
    check("ld_dat0", 32'(rx0[2]), 32'hA001);
    check("ld_dat2", 32'(rx0[4]), 32'hC003);
    n = 0;
    for (int c = 5; c <= 149; c++) if (rx1[c] == 16'h03FF) n++;
    check("ld_tail_cnt", 32'(n), 145);
    check("ld_x1_after", 32'(rx1[150]), 0);
    n = 0;
    for (int c = 1; c <= 155; c++) n += int'(rmode[c]);
    check("ld_mode_cnt", 32'(n), 148);
    check("ld_mode149", 32'(rmode[149]), 1);
    check("ld_mode150", 32'(rmode[150]), 0);
    check("ld_done149", 32'(rdone[149]), 0);
    check("ld_done150", 32'(rdone[150]), 1);
    n = 0;
    for (int c = 1; c <= 155; c++) n += int'(rdone[c]);
    check("ld_done_cnt", 32'(n), 1);

    // Load with one idle cycle between word 0 and word 1
    seq(1, 0, 155, 2, 0, 0);
    check("lg_rdy_gap", 32'(rrdy[2]), 1);
    check("lg_tag_idle", 32'(rx1[3]), 32'h3FF);
    check("lg_tag1", 32'(rx1[4]), 5);
    check("lg_tag2", 32'(rx1[5]), 144);
    check("lg_dat1", 32'(rx0[4]), 32'hB002);
    check("lg_done150", 32'(rdone[150]), 0);
    check("lg_done151", 32'(rdone[151]), 1);

    // Run: beats=9, passes=2, drain=4
    seq(0, 1, 30, 0, 0, 0);
    check("rn_busy1", 32'(rbusy[1]), 1);
    check("rn_vld1", 32'(rvld[1]), 0);
    check("rn_vld2", 32'(rvld[2]), 3);
    check("rn_vld3", 32'(rvld[3]), 1);
    check("rn_vld10", 32'(rvld[10]), 1);
    check("rn_gap11", 32'(rvld[11]), 0);
    check("rn_vld12", 32'(rvld[12]), 3);
    check("rn_vld20", 32'(rvld[20]), 1);
    check("rn_gap21", 32'(rvld[21]), 0);
    n = 0;
    for (int c = 1; c <= 30; c++) if (rvld[c] == 2'b01) n++;
    check("rn_beat_cnt", 32'(n), 16);
    n = 0;
    for (int c = 22; c <= 25; c++) n += int'(rvld[c] != 2'b00);
    check("rn_drain_idle", 32'(n), 0);
    check("rn_done25", 32'(rdone[25]), 0);
    check("rn_done26", 32'(rdone[26]), 1);
    check("rn_x0_2", 32'(rx0[2]), 32'h0101);
    check("rn_x1_5", 32'(rx1[5]), 32'h0204);
    check("rn_attr5", 32'(rattr[5]), 1);
    check("rn_k5", 32'(rk[5]), 3);
    check("rn_attr27", 32'(rattr[27]), 0);
    check("rn_err", 32'(rerr[26]), 0);

    // Underrun at beat 4 of 9, single pass, no drain
    cfg_passes = 16'd1; cfg_drain = 16'd0;
    seq(0, 1, 16, 0, 0, 5);
    check("ur_err5", 32'(rerr[5]), 0);
    check("ur_vld6", 32'(rvld[6]), 1);
    check("ur_x0_6", 32'(rx0[6]), 0);
    check("ur_err6", 32'(rerr[6]), 1);
    check("ur_vld10", 32'(rvld[10]), 1);
    check("ur_gap11", 32'(rvld[11]), 0);
    check("ur_done12", 32'(rdone[12]), 1);
    check("ur_sticky", 32'(rerr[15]), 1);
    seq(0, 1, 14, 0, 0, 0);
    check("ur_clear", 32'(rerr[1]), 0);
    check("ur_clr_done", 32'(rdone[12]), 1);

    // Load and run together, plus a run poke while busy
    seq(1, 1, 155, 0, 10, 0);
    check("sim_mode2", 32'(rmode[2]), 1);
    n = 0;
    for (int c = 1; c <= 155; c++) n += int'(rvld[c] != 2'b00);
    check("sim_no_vld", 32'(n), 0);
    check("sim_mode150", 32'(rmode[150]), 0);
    check("sim_done150", 32'(rdone[150]), 1);
    check("sim_idle_end", 32'(rbusy[155]), 0);

    // Async reset in the middle of the tail
    cmd_load = 1'b1;
    @(posedge clk); #1;
    cmd_load = 1'b0;
    w_val = 1'b1;
    w_data = 16'h1234; w_idx = 10'd7;
    repeat (49) @(posedge clk);
    #1;
    check("ar_pre_mode", 32'(mode_kernel_load), 1);
    arst_n = 1'b0;
    #1;
    check("ar_mode", 32'(mode_kernel_load), 0);
    check("ar_x1", 32'(x_entrance1), 0);
    check("ar_busy", 32'(busy), 0);
    check("ar_done", 32'(done), 0);
    w_val = 1'b0;
    @(posedge clk); #1;
    arst_n = 1'b1;
    n = 0;
    for (int c = 0; c < 160; c++) begin
      n += int'(done) + int'(busy);
      @(posedge clk); #1;
    end
    check("ar_no_done", 32'(n), 0);
    seq(1, 0, 155, 0, 0, 0);
    check("ar_reload_t2", 32'(rx1[4]), 144);
    check("ar_reload_done", 32'(rdone[150]), 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
